// File: rtl/rpn_sequencer_pkg.sv
// Shared constants for the RPN sequencer: stack command codes, token kinds,
// error codes, controller states and the stack depth limit.
package rpn_sequencer_pkg;

    localparam int STK_DEPTH = 1024;
    localparam int DEPTH_W   = 11;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = 11'd1024;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    localparam logic [1:0] TK_OPND = 2'b00;
    localparam logic [1:0] TK_ADD  = 2'b01;
    localparam logic [1:0] TK_MUL  = 2'b10;
    localparam logic [1:0] TK_END  = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_FULL  = 2'b10;
    localparam logic [1:0] ERR_END   = 2'b11;

    typedef enum logic [3:0] {
        IDLE, DRAIN, FETCH, PUSH, EXEC, CAPT, POP2, PUSHR, FIN
    } state_t;

endpackage

// File: rtl/rpn_sequencer_stack.sv
// Stack datapath driven by the sequencer: push/pop storage plus a registered
// add/mul of the top two entries with a signed overflow flag.
module rpn_sequencer_stack import rpn_sequencer_pkg::*; #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         opcode,
    input  logic [N-1:0]       data,
    output logic [N-1:0]       result,
    output logic               ovf,
    output logic [DEPTH_W-1:0] level
);

    logic [N-1:0]        mem [STK_DEPTH];
    logic [DEPTH_W-1:0]  sp;
    logic [DEPTH_W-2:0]  top_i, nxt_i;
    logic signed [N-1:0]   a, b, sum;
    logic signed [2*N-1:0] ax, bx, prod;
    logic                add_ovf, mul_ovf;

    // sp = 1024 wraps the low index bits to 0, so top_i still lands on 1023
    assign top_i = sp[DEPTH_W-2:0] - 10'd1;
    assign nxt_i = sp[DEPTH_W-2:0] - 10'd2;
    assign a     = mem[nxt_i];
    assign b     = mem[top_i];
    assign sum   = a + b;
    assign ax    = {{N{a[N-1]}}, a};
    assign bx    = {{N{b[N-1]}}, b};
    assign prod  = ax * bx;

    assign add_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    assign mul_ovf = prod[2*N-1:N-1] != {(N+1){prod[N-1]}};
    assign level   = sp;

    always_ff @(posedge clk) begin
        if (opcode == OP_PUSH && sp != DEPTH_MAX)
            mem[sp[DEPTH_W-2:0]] <= data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp     <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (opcode)
                OP_PUSH: if (sp != DEPTH_MAX) sp <= sp + 11'd1;
                OP_POP:  if (sp != '0)        sp <= sp - 11'd1;
                OP_ADD: begin
                    result <= sum;
                    ovf    <= add_ovf;
                end
                OP_MUL: begin
                    result <= prod[N-1:0];
                    ovf    <= mul_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN expression controller: consumes operand/operator tokens and sequences
// push/pop/add/mul commands to an external stack, tracking depth locally.
module rpn_sequencer import rpn_sequencer_pkg::*; #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [1:0]   tok_kind,
    input  logic [N-1:0] tok_data,
    output logic [2:0]   stk_opcode,
    output logic [N-1:0] stk_data,
    input  logic [N-1:0] stk_result,
    input  logic         stk_ovf,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         ovf,
    output logic [1:0]   err
);

    state_t              state, state_n;
    logic [DEPTH_W-1:0]  depth, depth_n;
    logic [1:0]          kind_q, kind_n;
    logic [N-1:0]        data_q, data_n;
    logic [N-1:0]        cap, cap_n;
    logic [N-1:0]        shadow, shadow_n;
    logic [N-1:0]        result_n;
    logic                ovf_n;
    logic [1:0]          err_n;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            depth  <= '0;
            kind_q <= TK_OPND;
            data_q <= '0;
            cap    <= '0;
            shadow <= '0;
            result <= '0;
            ovf    <= 1'b0;
            err    <= ERR_OK;
        end else begin
            state  <= state_n;
            depth  <= depth_n;
            kind_q <= kind_n;
            data_q <= data_n;
            cap    <= cap_n;
            shadow <= shadow_n;
            result <= result_n;
            ovf    <= ovf_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        depth_n    = depth;
        kind_n     = kind_q;
        data_n     = data_q;
        cap_n      = cap;
        shadow_n   = shadow;
        result_n   = result;
        ovf_n      = ovf;
        err_n      = err;
        stk_opcode = OP_NOP;
        stk_data   = '0;
        tok_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (depth != '0) ? DRAIN : FETCH;
                    ovf_n   = 1'b0;
                    err_n   = ERR_OK;
                end
            end
            // leftovers from an aborted or malformed expression are discarded
            DRAIN: begin
                stk_opcode = OP_POP;
                depth_n    = depth - 11'd1;
                if (depth == 11'd1) state_n = FETCH;
            end
            FETCH: begin
                tok_ready = 1'b1;
                if (tok_valid) begin
                    kind_n = tok_kind;
                    data_n = tok_data;
                    case (tok_kind)
                        TK_OPND: begin
                            if (depth < DEPTH_MAX) state_n = PUSH;
                            else begin
                                err_n   = ERR_FULL;
                                state_n = FIN;
                            end
                        end
                        TK_ADD, TK_MUL: begin
                            if (depth < 11'd2) begin
                                err_n   = ERR_UNDER;
                                state_n = FIN;
                            end else state_n = EXEC;
                        end
                        default: begin
                            if (depth != 11'd1) err_n = ERR_END;
                            state_n = FIN;
                        end
                    endcase
                end
            end
            PUSH: begin
                stk_opcode = OP_PUSH;
                stk_data   = data_q;
                shadow_n   = data_q;
                depth_n    = depth + 11'd1;
                state_n    = FETCH;
            end
            EXEC: begin
                stk_opcode = (kind_q == TK_MUL) ? OP_MUL : OP_ADD;
                state_n    = CAPT;
            end
            // stack result is registered, so it is valid here, one cycle after EXEC
            CAPT: begin
                stk_opcode = OP_POP;
                depth_n    = depth - 11'd1;
                cap_n      = stk_result;
                ovf_n      = ovf | stk_ovf;
                state_n    = POP2;
            end
            POP2: begin
                stk_opcode = OP_POP;
                depth_n    = depth - 11'd1;
                state_n    = PUSHR;
            end
            PUSHR: begin
                stk_opcode = OP_PUSH;
                stk_data   = cap;
                shadow_n   = cap;
                depth_n    = depth + 11'd1;
                state_n    = FETCH;
            end
            FIN: begin
                done     = 1'b1;
                result_n = shadow;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench: sequencer beside the real stack, hand-computed expressions.
module tb_rpn_sequencer;
    import rpn_sequencer_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         tok_valid = 1'b0;
    logic [1:0]   tok_kind = 2'b00;
    logic [N-1:0] tok_data = '0;
    logic         tok_ready, busy, done, ovf, stk_ovf;
    logic [2:0]   stk_opcode;
    logic [N-1:0] stk_data, stk_result, result;
    logic [1:0]   err;
    logic [10:0]  level;
    logic [11:0]  ops = '0;

    int vectors = 0;
    int miscompares = 0;
    int lat, pops;

    always #5 clk = ~clk;

    // last four stack commands, oldest in the top bits
    always @(posedge clk) ops <= {ops[8:0], stk_opcode};

    rpn_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_kind(tok_kind), .tok_data(tok_data),
        .stk_opcode(stk_opcode), .stk_data(stk_data),
        .stk_result(stk_result), .stk_ovf(stk_ovf),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err)
    );

    rpn_sequencer_stack #(.N(N)) stk (
        .clk(clk), .rst(rst), .opcode(stk_opcode), .data(stk_data),
        .result(stk_result), .ovf(stk_ovf), .level(level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic go(output int npop);
        int g;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        npop = 0; g = 0;
        @(negedge clk);
        while (!tok_ready && g < 2000) begin
            if (stk_opcode == OP_POP) npop++;
            g++;
            @(negedge clk);
        end
        chk("fetch_rdy", tok_ready, 1);
    endtask

    task automatic tok(input logic [1:0] k, input logic [N-1:0] d, output int l);
        int g;
        tok_kind = k; tok_data = d; tok_valid = 1'b1; g = 0;
        while (!tok_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!tok_ready) chk("tok_rdy", tok_ready, 1);
        @(posedge clk); #1 tok_valid = 1'b0;
        l = 0;
        @(negedge clk);
        while (!tok_ready && !done && l < 50) begin
            l++;
            @(negedge clk);
        end
    endtask

    task automatic fin(input string tag, input logic [N-1:0] r, input logic o, input logic [1:0] e);
        chk({tag, "_done"}, done, 1);
        @(negedge clk);
        chk({tag, "_done_off"}, {busy, done}, 0);
        chk({tag, "_result"}, result, r);
        chk({tag, "_ovf"}, ovf, o);
        chk({tag, "_err"}, err, e);
    endtask

    initial begin
        #3;
        chk("rst_outputs", {stk_opcode, stk_data, tok_ready, busy, done, result, ovf, err}, 0);
        chk("rst_level", level, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // token offered while idle stays pending
        tok_valid = 1'b1; tok_kind = TK_OPND; tok_data = 4'd3;
        repeat (3) @(negedge clk);
        chk("idle_rdy", tok_ready, 0);
        chk("idle_level", level, 0);
        tok_valid = 1'b0;

        // 3 4 + = 7, with a start pulse mid-expression
        go(pops); chk("t1_drain", pops, 0);
        tok(TK_OPND, 4'd3, lat); chk("t1_push_lat", lat, 1);
        tok(TK_OPND, 4'd4, lat);
        start = 1'b1; @(posedge clk); #1 start = 1'b0; @(negedge clk);
        chk("t1_busy_start", {busy, tok_ready}, 2'b11);
        tok(TK_ADD, 4'd0, lat);
        chk("t1_op_lat", lat, 4);
        chk("t1_op_seq", ops, 12'h9FE);
        chk("t1_level", level, 1);
        tok(TK_END, 4'd0, lat);
        fin("t1", 4'd7, 1'b0, ERR_OK);

        // 5 4 + overflows to -7
        go(pops); chk("t2_drain", pops, 1);
        tok(TK_OPND, 4'd5, lat);
        tok(TK_OPND, 4'd4, lat);
        tok(TK_ADD, 4'd0, lat);
        tok(TK_END, 4'd0, lat);
        fin("t2", 4'h9, 1'b1, ERR_OK);

        // 3 -2 * 1 + = -5
        go(pops);
        tok(TK_OPND, 4'd3, lat);
        tok(TK_OPND, 4'hE, lat);
        tok(TK_MUL, 4'd0, lat);
        chk("t3_mul_seq", ops, 12'hBFE);
        tok(TK_OPND, 4'd1, lat);
        tok(TK_ADD, 4'd0, lat);
        tok(TK_END, 4'd0, lat);
        fin("t3", 4'hB, 1'b0, ERR_OK);

        // 3 + : operator underflow
        go(pops);
        tok(TK_OPND, 4'd3, lat);
        tok(TK_ADD, 4'd0, lat);
        fin("t4", 4'd3, 1'b0, ERR_UNDER);
        chk("t4_level", level, 1);

        // 1 2 end : leaves depth 2
        go(pops); chk("t5_drain", pops, 1);
        tok(TK_OPND, 4'd1, lat);
        tok(TK_OPND, 4'd2, lat);
        tok(TK_END, 4'd0, lat);
        fin("t5", 4'd2, 1'b0, ERR_END);
        chk("t5_level", level, 2);

        // reset during EXEC
        go(pops); chk("t6_drain", pops, 2);
        tok(TK_OPND, 4'd3, lat);
        tok(TK_OPND, 4'd4, lat);
        tok_kind = TK_ADD; tok_valid = 1'b1;
        @(posedge clk); #1 tok_valid = 1'b0;
        chk("t6_exec_op", stk_opcode, OP_ADD);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_outputs", {stk_opcode, stk_data, tok_ready, busy, done, result, ovf, err}, 0);
        chk("t6_rst_level", level, 0);
        @(negedge clk);
        chk("t6_rst_hold", {stk_opcode, tok_ready, busy}, 0);
        rst = 1'b1;
        @(negedge clk);
        go(pops); chk("t7_drain", pops, 0);
        tok(TK_OPND, 4'd2, lat);
        tok(TK_OPND, 4'd2, lat);
        tok(TK_ADD, 4'd0, lat);
        tok(TK_END, 4'd0, lat);
        fin("t7", 4'd4, 1'b0, ERR_OK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
